axil_rr_arb2: RTL
=================

// Module: axil_rr_arb2
// PURPOSE
//  2:1 AXI-Lite arbiter placed in front of the read-only stats register slave (hash/word/pkt counters).
//  Upstream port S0 is the PS GP master; port S1 is the on-fabric debug poller. One downstream port M.
//  One transaction (read or write) is in flight at a time, granted round-robin across masters.
//  The grant is held from address acceptance to response completion.
// PARAMETERS
//  ADDR_WIDTH  6   byte-address width, all ports
//  DATA_WIDTH  32  data width, all ports; strobe width is DATA_WIDTH/8
// PORTS  (n = 0,1; each line covers Sn_x (dir as given) and M_x (opposite dir), same width)
//  ACLK         in   1           clock
//  ARESETN      in   1           synchronous active-low reset
//  Sn_AWADDR    in   ADDR_WIDTH  write address
//  Sn_AWVALID   in   1           write address valid
//  Sn_AWREADY   out  1           write address ready
//  Sn_WDATA     in   DATA_WIDTH  write data
//  Sn_WSTRB     in   DATA_WIDTH/8 write strobes
//  Sn_WVALID    in   1           write data valid
//  Sn_WREADY    out  1           write data ready
//  Sn_BRESP     out  2           write response
//  Sn_BVALID    out  1           write response valid
//  Sn_BREADY    in   1           write response ready
//  Sn_ARADDR    in   ADDR_WIDTH  read address
//  Sn_ARVALID   in   1           read address valid
//  Sn_ARREADY   out  1           read address ready
//  Sn_RDATA     out  DATA_WIDTH  read data
//  Sn_RRESP     out  2           read response
//  Sn_RVALID    out  1           read data valid
//  Sn_RREADY    in   1           read data ready
//  grant_id     out  1           owning master; valid while busy=1
//  busy         out  1           1 in any state other than IDLE
// BEHAVIOUR
//  FSM states: IDLE, RD_A, RD_R, WR_AW, WR_B. Registered: state, grant_id, last_id, last_kind, aw_done, w_done.
//  Reset: state=IDLE, grant_id=0, last_id=1 (S0 wins first), last_kind=WR (read wins first), aw_done=w_done=0.
//  Reset: all Sn_/M_ VALID and READY outputs are 0; data and resp outputs are 0.
//  Reset mid-transaction: return to IDLE immediately, no response is completed; the slave shares ARESETN.
//  Request: req_n = Sn_ARVALID | Sn_AWVALID. In IDLE no ready/valid is forwarded; every Sn_*READY and M_*VALID is 0.
//  Master select: if only one req_n, grant it; if both, grant !last_id.
//  Kind select: if granted master has both AR and AW pending, pick !last_kind; otherwise pick the pending one.
//  Grant step: register grant_id, last_id, last_kind; go to RD_A or WR_AW. Arbitration costs 1 cycle.
//  Forwarding: combinational muxes selected by registered grant_id.
//  Non-granted master: all its READY/VALID outputs are 0.
//  RD_A: M_AR* = S[g]_AR*; S[g]_ARREADY = M_ARREADY. On M_ARVALID & M_ARREADY -> RD_R.
//  RD_R: M_RREADY = S[g]_RREADY; S[g]_R* = M_R*. On M_RVALID & M_RREADY -> IDLE.
//  WR_AW: forward AW until its handshake, then set aw_done and gate AW (VALID/READY 0).
//  WR_AW: W handled independently and identically, setting w_done; same-cycle handshakes are allowed.
//  WR_AW: when both done (incl. same cycle) -> WR_B, clear aw_done/w_done.
//  WR_B: forward B; on M_BVALID & M_BREADY -> IDLE.
//  Min latency (slave has 1-cycle regs): read = grant 1 + AR 1 + R 1 (next grant possible next cycle).
//  Grant never changes outside IDLE; an upstream VALID held during another master's transaction stays pending.
//  Responses (RRESP/BRESP) pass through unmodified; the arbiter never generates its own response.
// TESTING
//  1. S0 read 0x04 alone -> M_ARADDR=0x04; S0_RDATA=ro_word_count; S1 sees no VALID/READY; busy high 3 cycles.
//  2. S0,S1 ARVALID same cycle (0x00, 0x08) -> S0 served first, then S1; second tie -> S1 first.
//  3. S0 AR+AW pending after reset -> read first, then write; the write gets BRESP=OKAY.
//  4. S1 write: W valid 2 cycles before AW -> both forwarded once; exactly one B to S1; no AW/W duplicate on M.
//  5. S1 AR asserted during S0's RD_R with RREADY low 5 cycles -> S1 stalls; S1_ARREADY=0 until S0 R handshake.
//  6. ARESETN low in RD_R -> next cycle state=IDLE, all VALID/READY 0, busy=0; a fresh read then completes.

Source files
------------

// File: rtl/axil_rr_arb2_if.sv
// AXI-Lite channel bundle for the stats-slave arbiter: one instance per upstream port and one downstream.
// master drives requests/write data and response readies; slave drives the opposite directions.
interface axil_rr_arb2_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_rr_arb2.sv
// 2:1 round-robin AXI-Lite arbiter (PS GP master on s0, debug poller on s1) in front of the
// read-only stats slave. One transaction in flight; grant held from address accept to response.
module axil_rr_arb2 #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    axil_rr_arb2_if.slave    s0,
    axil_rr_arb2_if.slave    s1,
    axil_rr_arb2_if.master   m,
    output logic             grant_id,
    output logic             busy
);
    localparam int SW = DATA_WIDTH / 8;
    localparam logic KIND_RD = 1'b0;
    localparam logic KIND_WR = 1'b1;

    typedef enum logic [2:0] {IDLE, RD_A, RD_R, WR_AW, WR_B} state_e;

    state_e state_q, state_d;
    logic   grant_id_q, grant_id_d;
    logic   last_id_q, last_id_d;
    logic   last_kind_q, last_kind_d;
    logic   aw_done_q, aw_done_d;
    logic   w_done_q, w_done_d;

    logic                  g_arvalid, g_awvalid, g_wvalid, g_rready, g_bready;
    logic [ADDR_WIDTH-1:0] g_araddr, g_awaddr;
    logic [DATA_WIDTH-1:0] g_wdata;
    logic [SW-1:0]         g_wstrb;

    logic                  u_arready, u_awready, u_wready, u_rvalid, u_bvalid;
    logic [DATA_WIDTH-1:0] u_rdata;
    logic [1:0]            u_rresp, u_bresp;

    logic req0, req1, sel, ar_p, aw_p, pick_wr, aw_now, w_now;

    assign req0     = s0.arvalid | s0.awvalid;
    assign req1     = s1.arvalid | s1.awvalid;
    assign grant_id = grant_id_q;
    assign busy     = (state_q != IDLE);

    always_comb begin : upstream_mux
        g_arvalid = grant_id_q ? s1.arvalid : s0.arvalid;
        g_araddr  = grant_id_q ? s1.araddr  : s0.araddr;
        g_rready  = grant_id_q ? s1.rready  : s0.rready;
        g_awvalid = grant_id_q ? s1.awvalid : s0.awvalid;
        g_awaddr  = grant_id_q ? s1.awaddr  : s0.awaddr;
        g_wvalid  = grant_id_q ? s1.wvalid  : s0.wvalid;
        g_wdata   = grant_id_q ? s1.wdata   : s0.wdata;
        g_wstrb   = grant_id_q ? s1.wstrb   : s0.wstrb;
        g_bready  = grant_id_q ? s1.bready  : s0.bready;
    end

    always_comb begin : fsm
        state_d     = state_q;
        grant_id_d  = grant_id_q;
        last_id_d   = last_id_q;
        last_kind_d = last_kind_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        m.araddr    = '0;
        m.arvalid   = 1'b0;
        m.rready    = 1'b0;
        m.awaddr    = '0;
        m.awvalid   = 1'b0;
        m.wdata     = '0;
        m.wstrb     = '0;
        m.wvalid    = 1'b0;
        m.bready    = 1'b0;
        u_arready   = 1'b0;
        u_awready   = 1'b0;
        u_wready    = 1'b0;
        u_rvalid    = 1'b0;
        u_rdata     = '0;
        u_rresp     = '0;
        u_bvalid    = 1'b0;
        u_bresp     = '0;
        sel         = 1'b0;
        ar_p        = 1'b0;
        aw_p        = 1'b0;
        pick_wr     = 1'b0;
        aw_now      = 1'b0;
        w_now       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    sel     = (req0 & req1) ? ~last_id_q : req1;
                    ar_p    = sel ? s1.arvalid : s0.arvalid;
                    aw_p    = sel ? s1.awvalid : s0.awvalid;
                    pick_wr = (ar_p & aw_p) ? ~last_kind_q : aw_p;
                    grant_id_d  = sel;
                    last_id_d   = sel;
                    last_kind_d = pick_wr ? KIND_WR : KIND_RD;
                    state_d     = pick_wr ? WR_AW : RD_A;
                end
            end
            RD_A: begin
                m.araddr  = g_araddr;
                m.arvalid = g_arvalid;
                u_arready = m.arready;
                if (g_arvalid & m.arready) state_d = RD_R;
            end
            RD_R: begin
                m.rready = g_rready;
                u_rvalid = m.rvalid;
                u_rdata  = m.rdata;
                u_rresp  = m.rresp;
                if (m.rvalid & g_rready) state_d = IDLE;
            end
            WR_AW: begin
                // AW and W each pass through once; whichever finishes first is gated off.
                if (!aw_done_q) begin
                    m.awaddr  = g_awaddr;
                    m.awvalid = g_awvalid;
                    u_awready = m.awready;
                end
                if (!w_done_q) begin
                    m.wdata  = g_wdata;
                    m.wstrb  = g_wstrb;
                    m.wvalid = g_wvalid;
                    u_wready = m.wready;
                end
                aw_now = aw_done_q | (g_awvalid & m.awready);
                w_now  = w_done_q  | (g_wvalid & m.wready);
                if (aw_now & w_now) begin
                    state_d   = WR_B;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end else begin
                    aw_done_d = aw_now;
                    w_done_d  = w_now;
                end
            end
            WR_B: begin
                m.bready = g_bready;
                u_bvalid = m.bvalid;
                u_bresp  = m.bresp;
                if (m.bvalid & g_bready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin : downstream_route
        s0.arready = ~grant_id_q & u_arready;
        s0.awready = ~grant_id_q & u_awready;
        s0.wready  = ~grant_id_q & u_wready;
        s0.rvalid  = ~grant_id_q & u_rvalid;
        s0.rdata   = grant_id_q ? '0 : u_rdata;
        s0.rresp   = grant_id_q ? '0 : u_rresp;
        s0.bvalid  = ~grant_id_q & u_bvalid;
        s0.bresp   = grant_id_q ? '0 : u_bresp;
        s1.arready = grant_id_q & u_arready;
        s1.awready = grant_id_q & u_awready;
        s1.wready  = grant_id_q & u_wready;
        s1.rvalid  = grant_id_q & u_rvalid;
        s1.rdata   = grant_id_q ? u_rdata : '0;
        s1.rresp   = grant_id_q ? u_rresp : '0;
        s1.bvalid  = grant_id_q & u_bvalid;
        s1.bresp   = grant_id_q ? u_bresp : '0;
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q     <= IDLE;
            grant_id_q  <= 1'b0;
            last_id_q   <= 1'b1;
            last_kind_q <= KIND_WR;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_id_q  <= grant_id_d;
            last_id_q   <= last_id_d;
            last_kind_q <= last_kind_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
        end
    end
endmodule
